// File: rtl/genram_loader.sv
// Loadable byte-addressable RAM responder: byte-stream loader at bring-up, then
// bounds-checked multi-byte reads (1-cycle latency) and stores from the CPU side.
module genram_loader #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AW:0]                 addr,
    input  logic [EXTRA-1:0]            extra,
    input  logic [AW:0]                 lower_bound,
    input  logic [AW:0]                 upper_bound,
    output logic [(2**EXTRA)*DW-1:0]    data,
    output logic                        error,
    output logic                        ready,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [7:0]                  load_data,
    input  logic                        load_last,
    output logic                        load_ready,
    input  logic                        wr_en,
    input  logic [AW:0]                 wr_addr,
    input  logic [EXTRA-1:0]            wr_extra,
    input  logic [(2**EXTRA)*DW-1:0]    wr_data,
    output logic                        wr_error
);

    localparam int DEPTH = 2**(AW+1);
    localparam int NB    = 2**EXTRA;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t          state;
    state_t          nstate;
    logic [AW:0]     ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic [NB*DW-1:0] rd_word_p0;
    logic             legal_rd_p0;
    logic             legal_wr_p0;
    logic             load_xfer_p0;

    // Window and depth check; the end address is one bit wider so it cannot wrap.
    function automatic logic in_window(input logic [AW:0] a, input logic [EXTRA-1:0] e,
                                       input logic [AW:0] lo, input logic [AW:0] hi);
        logic [AW+1:0] last;
        last = {1'b0, a} + (AW+2)'(e);
        return (a >= lo) && (last <= {1'b0, hi}) && (last <= (AW+2)'(DEPTH-1));
    endfunction

    // Stage 0: request decode and combinational gather of the read bytes
    always_comb begin
        legal_rd_p0  = (state == READY) && in_window(addr, extra, lower_bound, upper_bound);
        legal_wr_p0  = (state == READY) && in_window(wr_addr, wr_extra, lower_bound, upper_bound);
        load_xfer_p0 = (state == LOAD) && load_valid && !load_start;
        rd_word_p0   = '0;
        for (int i = 0; i < NB; i++) begin
            if (i <= int'(extra))
                rd_word_p0[i*DW +: DW] = mem[addr + (AW+1)'(i)];
        end
        nstate = state;
        if (load_start)
            nstate = LOAD;
        else if (load_xfer_p0 && (load_last || ptr == (AW+1)'(DEPTH-1)))
            nstate = READY;
    end

    // Stage 1: registered control and read response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            data       <= '0;
            error      <= 1'b0;
            ready      <= 1'b0;
            load_ready <= 1'b0;
            wr_error   <= 1'b0;
        end else begin
            state      <= nstate;
            ready      <= (nstate == READY);
            load_ready <= (nstate == LOAD);
            if (load_start)
                ptr <= '0;
            else if (load_xfer_p0)
                ptr <= ptr + 1'b1;
            data     <= legal_rd_p0 ? rd_word_p0 : '0;
            error    <= !legal_rd_p0;
            wr_error <= wr_en && !legal_wr_p0;
        end
    end

    // Array is never reset; loader and store port are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (load_xfer_p0)
            mem[ptr] <= load_data;
        else if (wr_en && legal_wr_p0) begin
            for (int i = 0; i < NB; i++) begin
                if (i <= int'(wr_extra))
                    mem[wr_addr + (AW+1)'(i)] <= wr_data[i*DW +: DW];
            end
        end
    end

endmodule
